// File: rtl/vend_pkg.sv
// Shared types and helpers for the coin-operated vending controller.
// Holds the FSM state encoding, the default coin values and the CREDIT_W sizing check.
package vend_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    VEND    = 2'd1,
    CHANGE  = 2'd2
  } state_t;

  // Coin values are counted in 5-cent units.
  localparam int DEF_N_VAL = 1;
  localparam int DEF_D_VAL = 2;
  localparam int DEF_Q_VAL = 5;

  // The largest credit the FSM can ever hold is PRICE-1 plus one quarter.
  // That value must fit in credit_w bits.
  function automatic bit credit_w_ok(int credit_w, int price, int q_val);
    if (price < 1 || credit_w < 1 || credit_w > 30) return 1'b0;
    return (price - 1 + q_val) < (1 << credit_w);
  endfunction

endpackage

// File: rtl/vending_controller_coin_select.sv
// Combinational coin priority encoder.
// Accepts the highest-value coin present and flags any extra coins for rejection.
module coin_select
  import vend_pkg::*;
#(
  parameter int N_VAL    = DEF_N_VAL,
  parameter int D_VAL    = DEF_D_VAL,
  parameter int Q_VAL    = DEF_Q_VAL,
  parameter int CREDIT_W = 4
) (
  input  logic                nickel,
  input  logic                dime,
  input  logic                quarter,
  output logic                coin_valid,
  output logic [CREDIT_W-1:0] coin_val,
  output logic                multi_reject
);

  assign coin_valid   = nickel | dime | quarter;
  assign multi_reject = (nickel & dime) | (nickel & quarter) | (dime & quarter);

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    coin_val = '0;
    if (quarter)     coin_val = CREDIT_W'(Q_VAL);
    else if (dime)   coin_val = CREDIT_W'(D_VAL);
    else if (nickel) coin_val = CREDIT_W'(N_VAL);
  end

endmodule

// File: rtl/vending_controller.sv
// Coin-operated vending controller: accumulates credit toward PRICE, raises vend,
// then returns any overpayment or cancelled credit through a change handshake.
module vending_controller
  import vend_pkg::*;
#(
  parameter int PRICE    = 4,
  parameter int N_VAL    = DEF_N_VAL,
  parameter int D_VAL    = DEF_D_VAL,
  parameter int Q_VAL    = DEF_Q_VAL,
  parameter int CREDIT_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                nickel,
  input  logic                dime,
  input  logic                quarter,
  input  logic                cancel,
  input  logic                vend_ack,
  input  logic                change_ready,
  output logic                vend,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amt,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject,
  output logic                busy
);

  if (!credit_w_ok(CREDIT_W, PRICE, Q_VAL)) begin : g_bad_credit_w
    $error("vending_controller: CREDIT_W cannot hold PRICE-1+Q_VAL, or PRICE < 1");
  end

  localparam logic [CREDIT_W:0] PRICE_EXT = (CREDIT_W + 1)'(PRICE);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] change_q, change_d;
  logic                reject_d;
  logic                coin_valid;
  logic                multi_reject;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W:0]   sum;
  logic                vend_q, change_valid_q, reject_q, busy_q;

  coin_select #(
    .N_VAL   (N_VAL),
    .D_VAL   (D_VAL),
    .Q_VAL   (Q_VAL),
    .CREDIT_W(CREDIT_W)
  ) u_coin_select (
    .nickel      (nickel),
    .dime        (dime),
    .quarter     (quarter),
    .coin_valid  (coin_valid),
    .coin_val    (coin_val),
    .multi_reject(multi_reject)
  );

  // One extra bit so the price comparison cannot wrap.
  assign sum = {1'b0, credit_q} + {1'b0, coin_val};

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    change_d = change_q;
    reject_d = 1'b0;
    unique case (state_q)
      COLLECT: begin
        reject_d = multi_reject;
        if (cancel) begin
          // A coin arriving with cancel joins the refund; no price check.
          if (sum != '0) begin
            state_d  = CHANGE;
            change_d = sum[CREDIT_W-1:0];
            credit_d = '0;
          end
        end else if (coin_valid) begin
          if (sum >= PRICE_EXT) begin
            state_d  = VEND;
            credit_d = CREDIT_W'(sum - PRICE_EXT);
          end else begin
            credit_d = sum[CREDIT_W-1:0];
          end
        end
      end
      VEND: begin
        reject_d = coin_valid;
        if (vend_ack) begin
          if (credit_q != '0) begin
            state_d  = CHANGE;
            change_d = credit_q;
            credit_d = '0;
          end else begin
            state_d = COLLECT;
          end
        end
      end
      CHANGE: begin
        reject_d = coin_valid;
        if (change_ready) begin
          state_d  = COLLECT;
          change_d = '0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= COLLECT;
      credit_q       <= '0;
      change_q       <= '0;
      vend_q         <= 1'b0;
      change_valid_q <= 1'b0;
      reject_q       <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      change_q       <= change_d;
      vend_q         <= (state_d == VEND);
      change_valid_q <= (state_d == CHANGE);
      reject_q       <= reject_d;
      busy_q         <= (state_d != COLLECT);
    end
  end

  assign vend         = vend_q;
  assign change_valid = change_valid_q;
  assign change_amt   = change_q;
  assign credit       = credit_q;
  assign coin_reject  = reject_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_vending_controller.sv
// Directed self-checking bench for vending_controller with default parameters (PRICE=4).
// Inputs change 1ns after a rising edge; outputs are sampled at that same point.
module tb_vending_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       nickel = 1'b0, dime = 1'b0, quarter = 1'b0;
  logic       cancel = 1'b0, vend_ack = 1'b0, change_ready = 1'b0;
  logic       vend, change_valid, coin_reject, busy;
  logic [3:0] change_amt, credit;

  int checks = 0;
  int errors = 0;

  vending_controller dut (
    .clk         (clk),
    .reset       (reset),
    .nickel      (nickel),
    .dime        (dime),
    .quarter     (quarter),
    .cancel      (cancel),
    .vend_ack    (vend_ack),
    .change_ready(change_ready),
    .vend        (vend),
    .change_valid(change_valid),
    .change_amt  (change_amt),
    .credit      (credit),
    .coin_reject (coin_reject),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic n, input logic d, input logic q);
    nickel = n; dime = d; quarter = q;
    tick();
    nickel = 1'b0; dime = 1'b0; quarter = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (vend !== 1'b0) begin errors++; $display("FAIL reset_vend: got %b want 0", vend); end
    checks++; if (change_valid !== 1'b0) begin errors++; $display("FAIL reset_change_valid: got %b want 0", change_valid); end
    checks++; if (change_amt !== 4'd0) begin errors++; $display("FAIL reset_change_amt: got %0d want 0", change_amt); end
    checks++; if (credit !== 4'd0) begin errors++; $display("FAIL reset_credit: got %0d want 0", credit); end
    checks++; if (coin_reject !== 1'b0) begin errors++; $display("FAIL reset_coin_reject: got %b want 0", coin_reject); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_exact_payment();
    for (int i = 1; i <= 3; i++) begin
      coin(1, 0, 0);
      checks++; if (credit !== 4'(i)) begin errors++; $display("FAIL exact_credit_%0d: got %0d want %0d", i, credit, i); end
      checks++; if (vend !== 1'b0) begin errors++; $display("FAIL exact_novend_%0d: got %b want 0", i, vend); end
    end
    coin(1, 0, 0);
    checks++; if (vend !== 1'b1) begin errors++; $display("FAIL exact_vend: got %b want 1", vend); end
    checks++; if (credit !== 4'd0) begin errors++; $display("FAIL exact_vend_credit: got %0d want 0", credit); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL exact_busy: got %b want 1", busy); end
    vend_ack = 1'b1; tick(); vend_ack = 1'b0;
    checks++; if (vend !== 1'b0) begin errors++; $display("FAIL exact_ack_vend: got %b want 0", vend); end
    checks++; if (change_valid !== 1'b0) begin errors++; $display("FAIL exact_no_change: got %b want 0", change_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL exact_idle: got %b want 0", busy); end
  endtask

  task automatic test_overpayment();
    coin(0, 1, 0);
    checks++; if (credit !== 4'd2) begin errors++; $display("FAIL over_credit_dime: got %0d want 2", credit); end
    coin(0, 0, 1);
    checks++; if (vend !== 1'b1) begin errors++; $display("FAIL over_vend: got %b want 1", vend); end
    checks++; if (credit !== 4'd3) begin errors++; $display("FAIL over_credit_rem: got %0d want 3", credit); end
    vend_ack = 1'b1; tick(); vend_ack = 1'b0;
    checks++; if (change_valid !== 1'b1) begin errors++; $display("FAIL over_change_valid: got %b want 1", change_valid); end
    checks++; if (change_amt !== 4'd3) begin errors++; $display("FAIL over_change_amt: got %0d want 3", change_amt); end
    checks++; if (credit !== 4'd0) begin errors++; $display("FAIL over_credit_cleared: got %0d want 0", credit); end
    checks++; if (vend !== 1'b0) begin errors++; $display("FAIL over_vend_dropped: got %b want 0", vend); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (change_valid !== 1'b1 || change_amt !== 4'd3) begin errors++; $display("FAIL over_stall_%0d: got valid=%b amt=%0d want valid=1 amt=3", i, change_valid, change_amt); end
    end
    change_ready = 1'b1; tick(); change_ready = 1'b0;
    checks++; if (change_valid !== 1'b0 || change_amt !== 4'd0) begin errors++; $display("FAIL over_done: got valid=%b amt=%0d want valid=0 amt=0", change_valid, change_amt); end
    checks++; if (busy !== 1'b0 || credit !== 4'd0) begin errors++; $display("FAIL over_idle: got busy=%b credit=%0d want busy=0 credit=0", busy, credit); end
  endtask

  task automatic test_cancel();
    coin(0, 1, 0);
    checks++; if (credit !== 4'd2) begin errors++; $display("FAIL cancel_credit: got %0d want 2", credit); end
    cancel = 1'b1; coin(1, 0, 0); cancel = 1'b0;
    checks++; if (change_valid !== 1'b1 || change_amt !== 4'd3) begin errors++; $display("FAIL cancel_refund: got valid=%b amt=%0d want valid=1 amt=3", change_valid, change_amt); end
    checks++; if (vend !== 1'b0 || credit !== 4'd0) begin errors++; $display("FAIL cancel_novend: got vend=%b credit=%0d want vend=0 credit=0", vend, credit); end
    change_ready = 1'b1; tick(); change_ready = 1'b0;
    checks++; if (change_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL cancel_done: got valid=%b busy=%b want 0 0", change_valid, busy); end
    cancel = 1'b1; tick(); cancel = 1'b0;
    checks++; if (change_valid !== 1'b0 || busy !== 1'b0 || credit !== 4'd0) begin errors++; $display("FAIL cancel_zero: got valid=%b busy=%b credit=%0d want 0 0 0", change_valid, busy, credit); end
  endtask

  task automatic test_busy_reject();
    coin(0, 1, 0);
    coin(0, 0, 1);
    checks++; if (vend !== 1'b1 || credit !== 4'd3) begin errors++; $display("FAIL rej_setup: got vend=%b credit=%0d want vend=1 credit=3", vend, credit); end
    coin(0, 0, 1);
    checks++; if (coin_reject !== 1'b1) begin errors++; $display("FAIL rej_vend_pulse: got %b want 1", coin_reject); end
    checks++; if (credit !== 4'd3 || vend !== 1'b1) begin errors++; $display("FAIL rej_vend_hold: got credit=%0d vend=%b want credit=3 vend=1", credit, vend); end
    tick();
    checks++; if (coin_reject !== 1'b0) begin errors++; $display("FAIL rej_vend_oneshot: got %b want 0", coin_reject); end
    vend_ack = 1'b1; tick(); vend_ack = 1'b0;
    coin(0, 0, 1);
    checks++; if (coin_reject !== 1'b1) begin errors++; $display("FAIL rej_change_pulse: got %b want 1", coin_reject); end
    checks++; if (change_amt !== 4'd3 || credit !== 4'd0 || change_valid !== 1'b1) begin errors++; $display("FAIL rej_change_hold: got amt=%0d credit=%0d valid=%b want 3 0 1", change_amt, credit, change_valid); end
    tick();
    checks++; if (coin_reject !== 1'b0) begin errors++; $display("FAIL rej_change_oneshot: got %b want 0", coin_reject); end
    change_ready = 1'b1; tick(); change_ready = 1'b0;
  endtask

  task automatic test_simultaneous();
    coin(1, 1, 0);
    checks++; if (credit !== 4'd2) begin errors++; $display("FAIL simul_credit: got %0d want 2", credit); end
    checks++; if (coin_reject !== 1'b1) begin errors++; $display("FAIL simul_reject: got %b want 1", coin_reject); end
    tick();
    checks++; if (coin_reject !== 1'b0 || credit !== 4'd2) begin errors++; $display("FAIL simul_after: got reject=%b credit=%0d want 0 2", coin_reject, credit); end
    cancel = 1'b1; tick(); cancel = 1'b0;
    checks++; if (change_amt !== 4'd2) begin errors++; $display("FAIL simul_refund: got %0d want 2", change_amt); end
    change_ready = 1'b1; tick(); change_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    vend_ack = 1'b1; change_ready = 1'b1;
    coin(0, 1, 0);
    coin(0, 0, 1);
    checks++; if (vend !== 1'b1 || credit !== 4'd3) begin errors++; $display("FAIL b2b_vend: got vend=%b credit=%0d want 1 3", vend, credit); end
    tick();
    checks++; if (change_valid !== 1'b1 || change_amt !== 4'd3 || vend !== 1'b0) begin errors++; $display("FAIL b2b_change: got valid=%b amt=%0d vend=%b want 1 3 0", change_valid, change_amt, vend); end
    coin(1, 0, 0);
    checks++; if (busy !== 1'b0 || change_valid !== 1'b0) begin errors++; $display("FAIL b2b_collect: got busy=%b valid=%b want 0 0", busy, change_valid); end
    checks++; if (credit !== 4'd0 || coin_reject !== 1'b1) begin errors++; $display("FAIL b2b_edge_coin_rejected: got credit=%0d reject=%b want 0 1", credit, coin_reject); end
    coin(1, 0, 0);
    checks++; if (credit !== 4'd1 || coin_reject !== 1'b0) begin errors++; $display("FAIL b2b_coin_accepted: got credit=%0d reject=%b want 1 0", credit, coin_reject); end
    cancel = 1'b1; tick(); cancel = 1'b0;
    checks++; if (change_valid !== 1'b1 || change_amt !== 4'd1) begin errors++; $display("FAIL b2b_cancel: got valid=%b amt=%0d want 1 1", change_valid, change_amt); end
    tick();
    checks++; if (busy !== 1'b0 || change_amt !== 4'd0) begin errors++; $display("FAIL b2b_cancel_done: got busy=%b amt=%0d want 0 0", busy, change_amt); end
    vend_ack = 1'b0; change_ready = 1'b0;
  endtask

  task automatic test_reset_mid_vend();
    coin(0, 1, 0);
    coin(0, 0, 1);
    checks++; if (vend !== 1'b1) begin errors++; $display("FAIL rst_setup: got %b want 1", vend); end
    #2 reset = 1'b1;
    #1;
    checks++; if (vend !== 1'b0 || credit !== 4'd0 || change_valid !== 1'b0) begin errors++; $display("FAIL rst_async: got vend=%b credit=%0d valid=%b want 0 0 0", vend, credit, change_valid); end
    checks++; if (busy !== 1'b0 || change_amt !== 4'd0) begin errors++; $display("FAIL rst_async_busy: got busy=%b amt=%0d want 0 0", busy, change_amt); end
    @(negedge clk);
    reset = 1'b0;
    tick();
    for (int i = 1; i <= 3; i++) coin(1, 0, 0);
    checks++; if (credit !== 4'd3) begin errors++; $display("FAIL rst_after_credit: got %0d want 3", credit); end
    coin(1, 0, 0);
    checks++; if (vend !== 1'b1 || credit !== 4'd0) begin errors++; $display("FAIL rst_after_vend: got vend=%b credit=%0d want 1 0", vend, credit); end
    vend_ack = 1'b1; tick(); vend_ack = 1'b0;
    checks++; if (busy !== 1'b0 || change_valid !== 1'b0) begin errors++; $display("FAIL rst_after_idle: got busy=%b valid=%b want 0 0", busy, change_valid); end
  endtask

  initial begin
    test_reset();
    test_exact_payment();
    test_overpayment();
    test_cancel();
    test_busy_reject();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_vend();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vending_controller.md
# vending_controller

Parametrised coin-operated vending controller for the FSM library. It accepts nickel, dime and quarter pulses and accumulates credit toward a configurable price. When credit reaches the price it issues a vend request and holds it until acknowledged, then returns any overpayment through a change handshake. A cancel input refunds partial credit.

## Interface
- `PRICE`, default 4: item price in 5-cent units; must be at least 1.
- `N_VAL`, default 1: nickel value in 5-cent units.
- `D_VAL`, default 2: dime value in 5-cent units.
- `Q_VAL`, default 5: quarter value in 5-cent units.
- `CREDIT_W`, default 4: credit and change width; must hold `PRICE-1+Q_VAL`, checked at elaboration.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `nickel`, `dime`, `quarter` in 1 each: one-cycle coin pulses, synchronous to `clk`.
- `cancel` in 1: refund request, level sampled each cycle.
- `vend_ack` in 1: dispenser accepts the vend.
- `change_ready` in 1: coin hopper accepts the change amount.
- `vend` out 1: vend request, registered.
- `change_valid` out 1: change amount valid, registered.
- `change_amt` out `CREDIT_W`: refund in 5-cent units, valid with `change_valid`.
- `credit` out `CREDIT_W`: current accumulated credit, registered.
- `coin_reject` out 1: one-cycle pulse; a coin was not accepted.
- `busy` out 1: high in VEND or CHANGE.

## Operation
- States: COLLECT, VEND, CHANGE. Reset state is COLLECT with credit 0.
- Coin select: if more than one coin input is high in a cycle, the highest value is accepted (quarter > dime > nickel). The others are rejected.
- COLLECT with an accepted coin of value v, and no cancel:
  - If `credit+v >= PRICE`: go to VEND; `credit` becomes `credit+v-PRICE`.
  - Otherwise: `credit` becomes `credit+v`; stay in COLLECT.
- COLLECT with `cancel` high:
  - Cancel wins over any same-cycle coin. That coin is added to the refund, with no price check.
  - If the resulting refund is greater than 0: go to CHANGE with `change_amt` set to the refund; `credit` reads 0.
  - If the refund is 0: no action.
- VEND: `vend` is held high until a cycle in which `vend_ack` is high.
  - On that edge: go to CHANGE if `credit > 0` (`change_amt` = `credit`, `credit` reads 0), otherwise go to COLLECT.
  - `cancel` is ignored in VEND.
- CHANGE: `change_valid` is held high and `change_amt` is held stable until a cycle in which `change_ready` is high. On that edge: go to COLLECT and clear `change_amt`.
- Any coin arriving in VEND or CHANGE is rejected and credit is unchanged.
- Reset mid-operation: state returns to COLLECT, and credit, `vend`, `change_valid` and `change_amt` go to 0. Held credit is forfeited.

## Timing
- All outputs are registered; reset value of every output is 0.
- Coin to `credit` update: 1 cycle.
- Coin completing the price to `vend` high: 1 cycle.
- `vend_ack` edge to `change_valid` high (or return to COLLECT): 1 cycle.
- `change_ready` edge to COLLECT: 1 cycle. A coin in that following cycle is accepted.
- `coin_reject` pulses high for 1 cycle, in the cycle after the rejected coin.
- Back-to-back handshakes: `vend_ack` or `change_ready` held permanently high completes each handshake in its minimum 1 cycle.
- Minimum full transaction with change: coin edge, then VEND, then CHANGE, then COLLECT, taking 3 cycles.

## Structure
- Package `vend_pkg`:
  - State enum (COLLECT, VEND, CHANGE).
  - Default coin-value localparams.
  - Width-check function for `CREDIT_W`.
- Sub-module `coin_select`: combinational priority encoder.
  - Inputs: three coin pulses.
  - Outputs: accepted coin valid, accepted value (`CREDIT_W` bits), multi-coin reject flag.
- Top level: FSM, credit register, change register and output registers.

## Test plan
- Exact payment: with PRICE=4, pulse nickel ×4 → `credit` reads 1, 2, 3. On the 4th nickel, `vend`=1 with `credit` 0. `vend_ack` → COLLECT with no `change_valid`.
- Overpayment: dime then quarter → `credit`=2, then `vend`=1 with `credit`=3. `vend_ack` → `change_valid`=1, `change_amt`=3. `change_ready` after 2 stall cycles → COLLECT, `credit`=0.
- Cancel: dime, then `cancel` together with a nickel → `change_amt`=3 and no vend. `cancel` with credit 0 → no state change.
- Busy reject: a quarter pulse during VEND (`vend_ack` held low) → `coin_reject` pulses high and `credit` is unchanged. Same check in CHANGE.
- Simultaneous coins: nickel and dime in the same cycle → `credit`=2 and `coin_reject`=1 for one cycle.
- Reset mid-VEND: assert `reset` asynchronously while `vend`=1 → `vend`, `credit` and `change_valid` are 0 immediately. After release, 4 nickels vend normally.
